pgr_fft_stage_sched: RTL

// - Sequences the radix-2 DIT butterfly stages of the burst FFT/IFFT core between input-done and calculate-done.
// - Started by fft_idone from pgr_fft_ctrl; returns the fft_cdone pulse to it.
// - Generates in-place RAM read/write addresses, the twiddle index and the stage index.
// - Input RAM is already bit-reverse ordered by the load path; this block never reorders it.

---
 rtl/pgr_fft_pkg.sv | 27 ++
 rtl/pgr_fft_stage_sched_if.sv | 30 +++
 rtl/pgr_fft_addr_dly.sv | 53 +++++
 rtl/pgr_fft_stage_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pgr_fft_pkg.sv
// Shared definitions for the burst FFT control path: scheduler FSM encoding,
// minimum transform length and a constant-evaluable clog2.
package pgr_fft_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_READ  = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    localparam int unsigned LEV_MIN = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = 32'(i) + 32'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pgr_fft_stage_sched_if.sv
// Handshake and address bus between pgr_fft_ctrl / butterfly datapath and the
// stage scheduler. The scheduler is the slave of the start/lev_limit request.
interface pgr_fft_stage_sched_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  start;
    logic [3:0]            lev_limit;
    logic                  busy;
    logic [3:0]            stage;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [ADDR_WIDTH-2:0] tw_addr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [ADDR_WIDTH-1:0] wr_addr_b;
    logic                  cdone;

    modport master (
        output start, lev_limit,
        input  busy, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  wr_en, wr_addr_a, wr_addr_b, cdone
    );

    modport slave (
        input  start, lev_limit,
        output busy, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output wr_en, wr_addr_a, wr_addr_b, cdone
    );
endinterface

// File: rtl/pgr_fft_addr_dly.sv
// Mirrors the butterfly pipeline: carries {valid, addr_a, addr_b} from read
// issue to write issue, and flags the last write of a read burst.
module pgr_fft_addr_dly #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    output logic          o_valid,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b,
    output logic          o_last
);
    logic          r_valid  [DEPTH];
    logic [AW-1:0] r_addr_a [DEPTH];
    logic [AW-1:0] r_addr_b [DEPTH];

    // Shift the read descriptor one slot per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_valid[i]  <= 1'b0;
                r_addr_a[i] <= {AW{1'b0}};
                r_addr_b[i] <= {AW{1'b0}};
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_addr_a[0] <= i_addr_a;
            r_addr_b[0] <= i_addr_b;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign o_valid  = r_valid[DEPTH-1];
    assign o_addr_a = r_addr_a[DEPTH-1];
    assign o_addr_b = r_addr_b[DEPTH-1];

    // A write with no read behind it is the final write of the burst
    generate
        if (DEPTH == 1) begin : g_single
            assign o_last = r_valid[0];
        end else begin : g_multi
            assign o_last = r_valid[DEPTH-1] & ~r_valid[DEPTH-2];
        end
    endgenerate
endmodule

// File: rtl/pgr_fft_stage_sched.sv
// Radix-2 DIT stage sequencer: walks every butterfly of every stage in place,
// waits out the butterfly pipeline between stages, then pulses cdone.
module pgr_fft_stage_sched
    import pgr_fft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned BF_LATENCY = 6
) (
    input logic                   clk,
    input logic                   rst_n,
    pgr_fft_stage_sched_if.slave  bus
);
    localparam int unsigned KW = ADDR_WIDTH - 1;

    state_e                r_state, w_state_nxt;
    logic [KW-1:0]         r_k, w_k_nxt, r_half_m1, w_half_m1;
    logic [3:0]            r_s, w_s_nxt, r_l, w_l_clamp;
    logic                  w_latch, w_drain_end;

    logic [KW-1:0]         w_one_k, w_span_k, w_pos_k, w_tw;
    logic [ADDR_WIDTH-1:0] w_one_a, w_span_a, w_a, w_b;
    logic [4:0]            w_tw_sh;

    logic                  w_rd_en_d, w_busy_d, w_cdone_d;
    logic [3:0]            w_stage_d;
    logic [ADDR_WIDTH-1:0] w_rd_a_d, w_rd_b_d;
    logic [KW-1:0]         w_tw_d;

    logic                  r_busy, r_rd_en, r_cdone;
    logic [3:0]            r_stage;
    logic [ADDR_WIDTH-1:0] r_rd_addr_a, r_rd_addr_b;
    logic [KW-1:0]         r_tw_addr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr_a, w_wr_addr_b;

    assign w_one_k = {{(KW-1){1'b0}}, 1'b1};
    assign w_one_a = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Clamp requested length and derive the last butterfly index of a stage
    always_comb begin
        w_l_clamp = bus.lev_limit;
        if (bus.lev_limit < 4'(LEV_MIN)) begin
            w_l_clamp = 4'(LEV_MIN);
        end else if (bus.lev_limit > 4'(ADDR_WIDTH)) begin
            w_l_clamp = 4'(ADDR_WIDTH);
        end else begin
            w_l_clamp = bus.lev_limit;
        end
        w_half_m1 = (w_one_k << (w_l_clamp - 4'd1)) - w_one_k;
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_k_nxt = {KW{1'b0}};
                w_s_nxt = 4'd0;
                if (bus.start) begin
                    w_state_nxt = ST_READ;
                    w_latch     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (r_k == r_half_m1) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_k_nxt = r_k + w_one_k;
                end
            end
            ST_DRAIN: begin
                if (!w_drain_end) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_s == r_l - 4'd1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_READ;
                    w_s_nxt     = r_s + 4'd1;
                    w_k_nxt     = {KW{1'b0}};
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = {KW{1'b0}};
                w_s_nxt     = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = {KW{1'b0}};
                w_s_nxt     = 4'd0;
            end
        endcase
    end

    // In-place addressing for the butterfly about to be presented
    always_comb begin
        w_span_k = w_one_k << w_s_nxt;
        w_span_a = w_one_a << w_s_nxt;
        w_pos_k  = w_k_nxt & (w_span_k - w_one_k);
        w_a      = (({1'b0, w_k_nxt} >> w_s_nxt) << (w_s_nxt + 4'd1)) | {1'b0, w_pos_k};
        w_b      = w_a + w_span_a;
        w_tw_sh  = 5'(KW) - {1'b0, w_s_nxt};
        w_tw     = w_pos_k << w_tw_sh;
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        w_rd_en_d = (w_state_nxt == ST_READ);
        w_busy_d  = (w_state_nxt != ST_IDLE);
        w_cdone_d = (w_state_nxt == ST_DONE);
        w_stage_d = 4'd0;
        w_rd_a_d  = {ADDR_WIDTH{1'b0}};
        w_rd_b_d  = {ADDR_WIDTH{1'b0}};
        w_tw_d    = {KW{1'b0}};
        if (w_rd_en_d) begin
            w_rd_a_d = w_a;
            w_rd_b_d = w_b;
            w_tw_d   = w_tw;
        end else begin
            w_rd_a_d = {ADDR_WIDTH{1'b0}};
            w_rd_b_d = {ADDR_WIDTH{1'b0}};
            w_tw_d   = {KW{1'b0}};
        end
        if (w_state_nxt == ST_READ || w_state_nxt == ST_DRAIN) begin
            w_stage_d = w_s_nxt;
        end else begin
            w_stage_d = 4'd0;
        end
    end

    // FSM state, butterfly/stage counters and latched frame length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_k       <= {KW{1'b0}};
            r_s       <= 4'd0;
            r_l       <= 4'd0;
            r_half_m1 <= {KW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_s     <= w_s_nxt;
            if (w_latch) begin
                r_l       <= w_l_clamp;
                r_half_m1 <= w_half_m1;
            end
        end
    end

    // Registered read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_cdone     <= 1'b0;
            r_stage     <= 4'd0;
            r_rd_addr_a <= {ADDR_WIDTH{1'b0}};
            r_rd_addr_b <= {ADDR_WIDTH{1'b0}};
            r_tw_addr   <= {KW{1'b0}};
        end else begin
            r_busy      <= w_busy_d;
            r_rd_en     <= w_rd_en_d;
            r_cdone     <= w_cdone_d;
            r_stage     <= w_stage_d;
            r_rd_addr_a <= w_rd_a_d;
            r_rd_addr_b <= w_rd_b_d;
            r_tw_addr   <= w_tw_d;
        end
    end

    pgr_fft_addr_dly #(
        .DEPTH (BF_LATENCY),
        .AW    (ADDR_WIDTH)
    ) u_addr_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (r_rd_en),
        .i_addr_a (r_rd_addr_a),
        .i_addr_b (r_rd_addr_b),
        .o_valid  (w_wr_en),
        .o_addr_a (w_wr_addr_a),
        .o_addr_b (w_wr_addr_b),
        .o_last   (w_drain_end)
    );

    assign bus.busy      = r_busy;
    assign bus.stage     = r_stage;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr_a = r_rd_addr_a;
    assign bus.rd_addr_b = r_rd_addr_b;
    assign bus.tw_addr   = r_tw_addr;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr_a = w_wr_addr_a;
    assign bus.wr_addr_b = w_wr_addr_b;
    assign bus.cdone     = r_cdone;
endmodule
